rom_arbiter: RTL

Two-port round-robin read scheduler for the on-chip 32-bit boot/code ROM (8192 words, one synchronous read per clock). It sits between two requesters, port 0 (instruction fetch) and port 1 (data/debug read), and the ROM macro. Each port gets a valid/ready request channel and a valid/ready response channel with a registered response slot. Interleaving the two ports sustains one ROM read per cycle.

---
 rtl/rom_arbiter_pkg.sv | 16 +
 rtl/rom_arbiter_if.sv | 30 +++
 rtl/rom_arbiter_rr_arb2.sv | 46 ++++
 rtl/rom_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg
//   Shared definitions for the two-port boot/code ROM read scheduler:
//   port count, port index type, default bus widths and the reset value
//   of the round-robin pointer.
package rom_arbiter_pkg;

    localparam int NPORTS         = 2;
    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 32;

    typedef logic [0:0] port_idx_t;

    // Pointer starts at port 1 so that port 0 wins the first tie.
    localparam port_idx_t LAST_GRANT_RESET = 1'b1;

endpackage : rom_arbiter_pkg

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
//   One requester channel of the ROM arbiter: a valid/ready read request
//   (req_*) and a valid/ready read response (rsp_*).
//   master : the requester (drives req_valid, req_addr, rsp_ready)
//   slave  : the arbiter   (drives req_ready, rsp_valid, rsp_data)
interface rom_arbiter_if
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface : rom_arbiter_if

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter. One-hot grant is combinational from
//   the eligibility vector; on a tie the input other than the last
//   granted one wins. The last-grant pointer advances on every grant.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   elig   : per-input eligibility
//   grant  : one-hot grant (all zero when nothing is eligible)
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    port_idx_t last_grant_q;
    port_idx_t last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_GRANT_RESET;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : rr_arb2

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Two-port round-robin read scheduler in front of a synchronous ROM
//   (one read per clock, data one cycle after the address is sampled).
//   Each port owns a single registered response slot; a port is only
//   granted when it has no read in flight and its slot is free or being
//   consumed this cycle. Grant-to-response latency is fixed at 2 cycles.
//   CLK    : clock shared with the ROM macro
//   RSTn   : asynchronous active-low reset
//   p0, p1 : requester channels (p0 = instruction fetch, p1 = data/debug)
//   rom_EN : ROM read strobe
//   rom_A  : ROM word address
//   rom_Do : ROM read data
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    rom_arbiter_if.slave          p0,
    rom_arbiter_if.slave          p1,
    output logic                  rom_EN,
    output logic [ADDR_WIDTH-1:0] rom_A,
    input  logic [DATA_WIDTH-1:0] rom_Do
);

    logic [NPORTS-1:0]     req_valid;
    logic [NPORTS-1:0]     rsp_ready;
    logic [ADDR_WIDTH-1:0] req_addr [NPORTS];
    logic [NPORTS-1:0]     elig;
    logic [NPORTS-1:0]     grant;

    logic [NPORTS-1:0]     inflight_q;
    logic [NPORTS-1:0]     inflight_d;
    logic [NPORTS-1:0]     rsp_valid_q;
    logic [NPORTS-1:0]     rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [NPORTS];
    logic [DATA_WIDTH-1:0] rsp_data_d [NPORTS];
    logic [ADDR_WIDTH-1:0] rom_a_q;
    logic [ADDR_WIDTH-1:0] rom_a_d;

    always_comb begin
        req_valid   = {p1.req_valid, p0.req_valid};
        rsp_ready   = {p1.rsp_ready, p0.rsp_ready};
        req_addr[0] = p0.req_addr;
        req_addr[1] = p1.req_addr;
    end

    // A port whose response slot is full and not being drained cannot
    // accept another read. RSTn gates eligibility so that no grant (and
    // no ROM strobe) leaks out while reset is held.
    always_comb begin
        elig = '0;
        for (int p = 0; p < NPORTS; p++) begin
            elig[p] = RSTn & req_valid[p] & ~inflight_q[p]
                      & ~(rsp_valid_q[p] & ~rsp_ready[p]);
        end
    end

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RSTn),
        .elig  (elig),
        .grant (grant)
    );

    // rom_A follows the granted port; on idle cycles it replays the last
    // issued address so the ROM address pins do not toggle.
    always_comb begin
        rom_EN = |grant;
        rom_A  = rom_a_q;
        if (grant[0]) begin
            rom_A = req_addr[0];
        end else if (grant[1]) begin
            rom_A = req_addr[1];
        end
        rom_a_d = rom_A;
    end

    // Capture (read in flight last cycle) takes priority over consume;
    // eligibility already guarantees the slot is free or draining then.
    always_comb begin
        inflight_d = grant;
        for (int p = 0; p < NPORTS; p++) begin
            rsp_valid_d[p] = rsp_valid_q[p];
            rsp_data_d[p]  = rsp_data_q[p];
            if (inflight_q[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_data_d[p]  = rom_Do;
            end else if (rsp_valid_q[p] && rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            rom_a_q     <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                rsp_data_q[p] <= '0;
            end
        end else begin
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            rom_a_q     <= rom_a_d;
            for (int p = 0; p < NPORTS; p++) begin
                rsp_data_q[p] <= rsp_data_d[p];
            end
        end
    end

    assign p0.req_ready = grant[0];
    assign p1.req_ready = grant[1];
    assign p0.rsp_valid = rsp_valid_q[0];
    assign p1.rsp_valid = rsp_valid_q[1];
    assign p0.rsp_data  = rsp_data_q[0];
    assign p1.rsp_data  = rsp_data_q[1];

    // Requesters must hold valid and address steady until accepted.
    a_p0_req_stable: assert property (@(posedge CLK) disable iff (!RSTn)
        (p0.req_valid && !p0.req_ready) |=> (p0.req_valid && $stable(p0.req_addr)));
    a_p1_req_stable: assert property (@(posedge CLK) disable iff (!RSTn)
        (p1.req_valid && !p1.req_ready) |=> (p1.req_valid && $stable(p1.req_addr)));

endmodule : rom_arbiter
